// File: rtl/pipe_hazard_tracker_pkg.sv
// Shared defaults and the stage-entry layout for the post-decode hazard tracker.
package pipe_hazard_tracker_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int PC_W_DEF   = 32;

  // Stage entry at the default widths of the ARM core. The tracker itself
  // re-declares this layout with its own ADDR_W/PC_W parameters.
  typedef struct packed {
    logic                  valid;
    logic                  wb_en;
    logic                  mem_r_en;
    logic [ADDR_W_DEF-1:0] dest;
    logic [PC_W_DEF-1:0]   pc;
  } stage_entry_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: step only when requested and not already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_tracker.sv
// Tracks instructions past ID through DEPTH stages, raises the RAW stall
// request for ID/IF, passes branch flush through, and reports retirement.
module pipe_hazard_tracker
  import pipe_hazard_tracker_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int PC_W   = PC_W_DEF,
  parameter int FWD_EN = 0,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_src1,
  input  logic [ADDR_W-1:0] id_src2,
  input  logic              id_two_src,
  input  logic              id_wb_en,
  input  logic              id_mem_r_en,
  input  logic [ADDR_W-1:0] id_dest,
  input  logic [PC_W-1:0]   id_pc,
  input  logic              branch_taken,
  output logic              hazard,
  output logic              flush,
  output logic [DEPTH-1:0]  stage_valid,
  output logic              retire_valid,
  output logic [PC_W-1:0]   retire_pc,
  output logic [ADDR_W-1:0] retire_dest,
  output logic              retire_wb_en,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  retire_cnt
);

  typedef struct packed {
    logic              valid;
    logic              wb_en;
    logic              mem_r_en;
    logic [ADDR_W-1:0] dest;
    logic [PC_W-1:0]   pc;
  } entry_t;

  entry_t stage_q [DEPTH];
  entry_t stage_d [DEPTH];
  entry_t id_entry;
  logic   raw_match;
  logic   accept;

  // An in-flight entry produces src if it will write that register.
  function automatic logic produces(input entry_t e, input logic [ADDR_W-1:0] src);
    return e.valid & e.wb_en & (e.dest == src);
  endfunction

  // RAW detection. Without forwarding every stage but the last (WB) is checked;
  // the register file writes before it reads, so WB never needs a stall.
  // With forwarding only a load sitting in EXE can't be bypassed in time.
  // NOTE: every signal assigned here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    raw_match = 1'b0;
    if (FWD_EN != 0) begin
      raw_match = stage_q[0].mem_r_en &
                  (produces(stage_q[0], id_src1) |
                   (id_two_src & produces(stage_q[0], id_src2)));
    end else begin
      for (int k = 0; k < DEPTH - 1; k++) begin
        raw_match = raw_match | produces(stage_q[k], id_src1) |
                    (id_two_src & produces(stage_q[k], id_src2));
      end
    end
  end

  // A taken branch squashes ID, so it overrides any stall request.
  assign hazard = id_valid & ~branch_taken & raw_match;
  assign flush  = branch_taken;
  assign accept = id_valid & ~hazard & ~branch_taken;

  // Entry built from the instruction currently in ID.
  always_comb begin
    id_entry          = '0;
    id_entry.valid    = 1'b1;
    id_entry.wb_en    = id_wb_en;
    id_entry.mem_r_en = id_mem_r_en;
    id_entry.dest     = id_dest;
    id_entry.pc       = id_pc;
  end

  // Shift: stage 0 takes ID or a bubble; older stages move down unconditionally.
  always_comb begin
    stage_d[0] = accept ? id_entry : entry_t'('0);
    for (int k = 1; k < DEPTH; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  // Stage registers.
  // NOTE: the whole stage array is reset, not just the valid bits, because
  // dest/pc feed retire outputs that must read 0 after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_q <= '{default: '0};
    end else begin
      stage_q <= stage_d;
    end
  end

  // Per-stage valid vector, bit 0 = EXE.
  always_comb begin
    stage_valid = '0;
    for (int k = 0; k < DEPTH; k++) begin
      stage_valid[k] = stage_q[k].valid;
    end
  end

  assign retire_valid = stage_q[DEPTH-1].valid;
  assign retire_pc    = stage_q[DEPTH-1].pc;
  assign retire_dest  = stage_q[DEPTH-1].dest;
  assign retire_wb_en = stage_q[DEPTH-1].wb_en;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst),
    .inc_i   (hazard),
    .count_o (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_retire_cnt (
    .clk     (clk),
    .rst_n   (rst),
    .inc_i   (retire_valid),
    .count_o (retire_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_tracker.sv
// Directed bench: three trackers share one stimulus stream
// (dut0: no forwarding, dut1: forwarding, dut2: no forwarding with 4-bit counters).
module tb_pipe_hazard_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_valid, id_two_src, id_wb_en, id_mem_r_en, branch_taken;
  logic [3:0]  id_src1, id_src2, id_dest;
  logic [31:0] id_pc;

  logic        h0, f0, rv0, rwb0;
  logic [2:0]  sv0;
  logic [31:0] rpc0;
  logic [3:0]  rd0;
  logic [15:0] sc0, rc0;

  logic        h1, f1, rv1, rwb1;
  logic [2:0]  sv1;
  logic [31:0] rpc1;
  logic [3:0]  rd1;
  logic [15:0] sc1, rc1;

  logic        h2, f2, rv2, rwb2;
  logic [2:0]  sv2;
  logic [31:0] rpc2;
  logic [3:0]  rd2;
  logic [3:0]  sc2, rc2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_tracker #(.DEPTH(3), .FWD_EN(0), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .id_dest(id_dest), .id_pc(id_pc), .branch_taken(branch_taken), .hazard(h0),
    .flush(f0), .stage_valid(sv0), .retire_valid(rv0), .retire_pc(rpc0),
    .retire_dest(rd0), .retire_wb_en(rwb0), .stall_cnt(sc0), .retire_cnt(rc0));

  pipe_hazard_tracker #(.DEPTH(3), .FWD_EN(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .id_dest(id_dest), .id_pc(id_pc), .branch_taken(branch_taken), .hazard(h1),
    .flush(f1), .stage_valid(sv1), .retire_valid(rv1), .retire_pc(rpc1),
    .retire_dest(rd1), .retire_wb_en(rwb1), .stall_cnt(sc1), .retire_cnt(rc1));

  pipe_hazard_tracker #(.DEPTH(3), .FWD_EN(0), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .id_dest(id_dest), .id_pc(id_pc), .branch_taken(branch_taken), .hazard(h2),
    .flush(f2), .stage_valid(sv2), .retire_valid(rv2), .retire_pc(rpc2),
    .retire_dest(rd2), .retire_wb_en(rwb2), .stall_cnt(sc2), .retire_cnt(rc2));

  task automatic drive(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                       input logic two, input logic wb, input logic mr,
                       input logic [3:0] d, input logic [31:0] pc);
    id_valid = v; id_src1 = s1; id_src2 = s2; id_two_src = two;
    id_wb_en = wb; id_mem_r_en = mr; id_dest = d; id_pc = pc;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    branch_taken = 1'b0;
  endtask

  // One active edge, then return on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    @(negedge clk); #1;
    checks++; if (sv0 !== 3'b000) begin errors++; $display("FAIL reset_stage_valid: got %b expected 000", sv0); end
    checks++; if (rv0 !== 1'b0) begin errors++; $display("FAIL reset_retire_valid: got %b expected 0", rv0); end
    checks++; if (rpc0 !== 32'd0) begin errors++; $display("FAIL reset_retire_pc: got %h expected 0", rpc0); end
    checks++; if (sc0 !== 16'd0 || rc0 !== 16'd0) begin errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", sc0, rc0); end
    checks++; if (h0 !== 1'b0 || f0 !== 1'b0) begin errors++; $display("FAIL reset_hazard_flush: got %b/%b expected 0/0", h0, f0); end
    do_reset();
  endtask

  // Three independent instructions, pc 0,4,8.
  task automatic test_independent();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'd12, 4'd13, 1'b1, 1'b1, 1'b0, 4'(1 + 3 * i), 32'(4 * i));
      #1;
      checks++; if (h0 !== 1'b0) begin errors++; $display("FAIL indep_hazard_%0d: got %b expected 0", i, h0); end
      tick();
    end
    idle();
    #1;
    checks++; if (sv0 !== 3'b111) begin errors++; $display("FAIL indep_stage_valid: got %b expected 111", sv0); end
    checks++; if (rv0 !== 1'b1 || rpc0 !== 32'd0) begin errors++; $display("FAIL indep_first_retire: got v=%b pc=%h expected v=1 pc=0", rv0, rpc0); end
    checks++; if (rd0 !== 4'd1 || rwb0 !== 1'b1) begin errors++; $display("FAIL indep_retire_dest: got %0d/%b expected 1/1", rd0, rwb0); end
    repeat (3) tick();
    #1;
    checks++; if (rc0 !== 16'd3) begin errors++; $display("FAIL indep_retire_cnt: got %0d expected 3", rc0); end
    checks++; if (rv0 !== 1'b0) begin errors++; $display("FAIL indep_drained: got %b expected 0", rv0); end
  endtask

  // ADD r1 then SUB r?,r1 without forwarding: two stall cycles.
  task automatic test_raw_nofwd();
    do_reset();
    drive(1'b1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 4'd1, 32'h100);
    tick();
    drive(1'b0, 4'd1, 4'd0, 1'b0, 1'b1, 1'b0, 4'd3, 32'h104);
    #1;
    checks++; if (h0 !== 1'b0) begin errors++; $display("FAIL raw_idle_no_hazard: got %b expected 0", h0); end
    id_valid = 1'b1;
    #1;
    checks++; if (h0 !== 1'b1) begin errors++; $display("FAIL raw_stall_exe: got %b expected 1", h0); end
    tick(); #1;
    checks++; if (h0 !== 1'b1) begin errors++; $display("FAIL raw_stall_mem: got %b expected 1", h0); end
    tick(); #1;
    checks++; if (h0 !== 1'b0) begin errors++; $display("FAIL raw_clear_wb: got %b expected 0", h0); end
    checks++; if (rv0 !== 1'b1 || rpc0 !== 32'h100) begin errors++; $display("FAIL raw_add_retire: got v=%b pc=%h expected v=1 pc=100", rv0, rpc0); end
    tick();
    idle();
    #1;
    checks++; if (sc0 !== 16'd2) begin errors++; $display("FAIL raw_stall_cnt: got %0d expected 2", sc0); end
    repeat (2) tick();
    #1;
    checks++; if (rv0 !== 1'b1 || rpc0 !== 32'h104) begin errors++; $display("FAIL raw_sub_retire: got v=%b pc=%h expected v=1 pc=104", rv0, rpc0); end
  endtask

  // Load-use with forwarding: one stall when src2 is used, none otherwise.
  task automatic test_load_use_fwd();
    do_reset();
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd2, 32'h200);
    tick();
    drive(1'b1, 4'd9, 4'd2, 1'b1, 1'b1, 1'b0, 4'd5, 32'h204);
    #1;
    checks++; if (h1 !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b expected 1", h1); end
    tick(); #1;
    checks++; if (h1 !== 1'b0) begin errors++; $display("FAIL lu_clear: got %b expected 0", h1); end
    tick();
    idle();
    #1;
    checks++; if (sc1 !== 16'd1) begin errors++; $display("FAIL lu_stall_cnt: got %0d expected 1", sc1); end
    checks++; if (sv1 !== 3'b101) begin errors++; $display("FAIL lu_stage_valid: got %b expected 101", sv1); end

    do_reset();
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd2, 32'h200);
    tick();
    drive(1'b1, 4'd9, 4'd2, 1'b0, 1'b1, 1'b0, 4'd5, 32'h204);
    #1;
    checks++; if (h1 !== 1'b0) begin errors++; $display("FAIL lu_one_src_no_stall: got %b expected 0", h1); end
    tick();
    idle();
    #1;
    checks++; if (sc1 !== 16'd0) begin errors++; $display("FAIL lu_one_src_cnt: got %0d expected 0", sc1); end
    checks++; if (sv1 !== 3'b011) begin errors++; $display("FAIL lu_one_src_valid: got %b expected 011", sv1); end
  endtask

  // Branch taken while ID holds a dependent instruction.
  task automatic test_branch_flush();
    do_reset();
    drive(1'b1, 4'd12, 4'd13, 1'b1, 1'b1, 1'b0, 4'd1, 32'h300);
    tick();
    drive(1'b1, 4'd12, 4'd13, 1'b1, 1'b1, 1'b0, 4'd4, 32'h304);
    tick();
    drive(1'b1, 4'd4, 4'd0, 1'b0, 1'b1, 1'b0, 4'd6, 32'h308);
    #1;
    checks++; if (h0 !== 1'b1) begin errors++; $display("FAIL br_pre_hazard: got %b expected 1", h0); end
    branch_taken = 1'b1;
    #1;
    checks++; if (h0 !== 1'b0 || f0 !== 1'b1) begin errors++; $display("FAIL br_priority: got hazard=%b flush=%b expected 0/1", h0, f0); end
    tick();
    idle();
    #1;
    checks++; if (f0 !== 1'b0) begin errors++; $display("FAIL br_flush_drop: got %b expected 0", f0); end
    checks++; if (sv0 !== 3'b110) begin errors++; $display("FAIL br_bubble: got %b expected 110", sv0); end
    checks++; if (rv0 !== 1'b1 || rpc0 !== 32'h300) begin errors++; $display("FAIL br_old0_retire: got v=%b pc=%h expected v=1 pc=300", rv0, rpc0); end
    tick(); #1;
    checks++; if (rv0 !== 1'b1 || rpc0 !== 32'h304) begin errors++; $display("FAIL br_old1_retire: got v=%b pc=%h expected v=1 pc=304", rv0, rpc0); end
    tick(); #1;
    checks++; if (rv0 !== 1'b0) begin errors++; $display("FAIL br_squashed: got %b expected 0", rv0); end
    tick(); #1;
    checks++; if (rc0 !== 16'd2 || sc0 !== 16'd0) begin errors++; $display("FAIL br_counters: got %0d/%0d expected retire 2 stall 0", rc0, sc0); end
  endtask

  // Reset pulled low between edges with a full pipe.
  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'd12, 4'd13, 1'b1, 1'b1, 1'b0, 4'(1 + 3 * i), 32'(32'h500 + 4 * i));
      tick();
    end
    idle();
    #1;
    checks++; if (sv0 !== 3'b111 || rc0 !== 16'd1) begin errors++; $display("FAIL ar_prefill: got valid=%b rcnt=%0d expected 111/1", sv0, rc0); end
    #1 rst = 1'b0;
    #1;
    checks++; if (sv0 !== 3'b000 || rv0 !== 1'b0) begin errors++; $display("FAIL ar_drop: got valid=%b rv=%b expected 000/0", sv0, rv0); end
    checks++; if (rc0 !== 16'd0 || sc0 !== 16'd0 || rpc0 !== 32'd0) begin errors++; $display("FAIL ar_clear: got rcnt=%0d scnt=%0d pc=%h expected 0/0/0", rc0, sc0, rpc0); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Self-dependent instruction held in ID: 2 stalls per 3 cycles.
  task automatic test_saturation();
    do_reset();
    drive(1'b1, 4'd1, 4'd0, 1'b0, 1'b1, 1'b0, 4'd1, 32'h400);
    repeat (21) tick();
    #1;
    checks++; if (sc2 !== 4'd14 || sc0 !== 16'd14) begin errors++; $display("FAIL sat_before: got %0d/%0d expected 14/14", sc2, sc0); end
    repeat (3) tick();
    #1;
    checks++; if (sc2 !== 4'd15) begin errors++; $display("FAIL sat_reach: got %0d expected 15", sc2); end
    repeat (21) tick();
    #1;
    checks++; if (sc2 !== 4'd15 || sc0 !== 16'd30) begin errors++; $display("FAIL sat_hold: got %0d/%0d expected 15/30", sc2, sc0); end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_independent();
    test_raw_nofwd();
    test_load_use_fwd();
    test_branch_flush();
    test_async_reset();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
